// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues synchronous ROM reads at pc_in and buffers {pc, word} pairs in a prefetch FIFO for decode.
// Optional build macro FETCH_STATS_EN adds saturating fetch/stall counters (fetch_cnt, stall_cnt).
module instr_fetch_unit #(
  parameter int AW    = 10,
  parameter int IW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  output logic          pc_incr,
  output logic [AW-1:0] imem_addr,
  output logic          imem_req,
  input  logic [IW-1:0] imem_rdata,
  input  logic          flush,
  input  logic          halt,
  output logic [IW-1:0] ir_data,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
`ifdef FETCH_STATS_EN
  output logic [15:0]   fetch_cnt,
  output logic [15:0]   stall_cnt,
`endif
  input  logic          ir_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] occupancy;
  logic          inflight;
  logic [AW-1:0] req_pc;
  logic          issue, push, pop;

  // In-flight words reserve a slot, so a response always has room to land.
  assign occupancy = count + CW'(inflight);
  assign issue     = !rst && !flush && !halt && (occupancy < CW'(DEPTH));
  assign imem_req  = issue;
  assign pc_incr   = issue;
  assign imem_addr = pc_in;

  // Decode link: a word transfers on every cycle where ir_valid and ir_ready
  // are both high; ir_valid never depends on ir_ready, and a flush cancels it.
  assign push     = inflight && !flush;
  assign pop      = ir_valid && ir_ready && !flush;
  assign ir_valid = (count != '0);
  assign ir_data  = ir_valid ? data_mem[rd_ptr] : '0;
  assign ir_pc    = ir_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc <= '0;
    end else if (issue) begin
      req_pc <= pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic stall;
  assign stall = ir_ready && !ir_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && fetch_cnt != 16'hFFFF)   fetch_cnt <= fetch_cnt + 16'd1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch/stall/flush/halt sequences with an expected-word queue.
module tb_instr_fetch_unit;
  localparam int AW    = 10;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_in = '0;
  logic          pc_incr;
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic [IW-1:0] imem_rdata = '0;
  logic          flush = 1'b0;
  logic          halt = 1'b0;
  logic [IW-1:0] ir_data;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [AW-1:0] pc_target = '0;
`ifdef FETCH_STATS_EN
  logic [15:0]   fetch_cnt;
  logic [15:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  logic [AW+IW-1:0] exp_q[$];

  instr_fetch_unit #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_incr(pc_incr),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .flush(flush), .halt(halt), .ir_data(ir_data), .ir_pc(ir_pc),
    .ir_valid(ir_valid),
`ifdef FETCH_STATS_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
    .ir_ready(ir_ready)
  );

  // clock / reset / environment models
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
    return {a[5:0], a} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    if (rst)           pc_in <= '0;
    else if (flush)    pc_in <= pc_target;
    else if (pc_incr)  pc_in <= pc_in + AW'(1);
  end

  always @(posedge clk) if (imem_req) imem_rdata <= rom_word(imem_addr);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // checking helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pc(input logic [AW-1:0] pc);
    exp_q.push_back({pc, rom_word(pc)});
  endtask

  // scoreboard monitor: every accepted word must match the queue head
  always @(negedge clk) begin
    if (!rst && ir_valid && ir_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(ir_pc), 32'hFFFF_FFFF);
      end else begin
        logic [AW+IW-1:0] e;
        e = exp_q.pop_front();
        check("ir_pc", 32'(ir_pc), 32'(e[AW+IW-1:IW]));
        check("ir_data", 32'(ir_data), 32'(e[IW-1:0]));
      end
    end
  end

  // driver tasks
  task automatic at_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input int k);
    at_cyc(k);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; halt = 1'b0; ir_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_pc_incr", 32'(pc_incr), 32'd0);
    check("rst_ir_data", 32'(ir_data), 32'd0);
    check("rst_ir_pc", 32'(ir_pc), 32'd0);
`ifdef FETCH_STATS_EN
    check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drained(input int k);
    sample(k);
    check("drained_ir_valid", 32'(ir_valid), 32'd0);
    check("drained_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // streaming with decode always ready
    do_reset();
    ir_ready = 1'b1;
    for (int i = 0; i < 6; i++) expect_pc(AW'(i));
    sample(0);
    check("t1_imem_req", 32'(imem_req), 32'd1);
    check("t1_pc_incr", 32'(pc_incr), 32'd1);
    check("t1_imem_addr", 32'(imem_addr), 32'd0);
    check("t1_valid_c0", 32'(ir_valid), 32'd0);
    sample(1);
    check("t1_valid_c1", 32'(ir_valid), 32'd0);
    check("t1_addr_c1", 32'(imem_addr), 32'd1);
    sample(2);
    check("t1_valid_c2", 32'(ir_valid), 32'd1);
    at_cyc(6);
    halt = 1'b1;
    sample(6);
    check("t1_halt_req", 32'(imem_req), 32'd0);
    drained(10);

    // fill with decode stalled, single-cycle pop, then drain
    do_reset();
    for (int i = 0; i < 6; i++) expect_pc(AW'(i));
    sample(4);
    check("t2_full_req_c4", 32'(imem_req), 32'd0);
    sample(6);
    check("t2_full_req_c6", 32'(imem_req), 32'd0);
    check("t2_full_valid", 32'(ir_valid), 32'd1);
    check("t2_full_head", 32'(ir_pc), 32'd0);
    at_cyc(7);
    ir_ready = 1'b1;
    at_cyc(8);
    ir_ready = 1'b0;
    sample(8);
    check("t3_reissue", 32'(imem_req), 32'd1);
    check("t3_reissue_addr", 32'(imem_addr), 32'd4);
    check("t3_head", 32'(ir_pc), 32'd1);
    sample(10);
    check("t3_refull_req", 32'(imem_req), 32'd0);
    check("t3_refull_valid", 32'(ir_valid), 32'd1);
    at_cyc(11);
    ir_ready = 1'b1;
    at_cyc(13);
    halt = 1'b1;
    drained(18);

    // flush with two buffered and one in flight
    do_reset();
    at_cyc(3);
    flush = 1'b1;
    pc_target = 10'h200;
    sample(3);
    check("t4_pre_valid", 32'(ir_valid), 32'd1);
    check("t4_flush_req", 32'(imem_req), 32'd0);
    at_cyc(4);
    flush = 1'b0;
    ir_ready = 1'b1;
    expect_pc(10'h200);
    expect_pc(10'h201);
    sample(4);
    check("t4_post_valid", 32'(ir_valid), 32'd0);
    check("t4_resume_req", 32'(imem_req), 32'd1);
    check("t4_resume_addr", 32'(imem_addr), 32'h200);
    sample(5);
    check("t4_stale_dropped", 32'(ir_valid), 32'd0);
    at_cyc(6);
    halt = 1'b1;
    drained(10);

    // halt with one word in flight
    do_reset();
    for (int i = 0; i < 3; i++) expect_pc(AW'(i));
    at_cyc(1);
    halt = 1'b1;
    sample(1);
    check("t5_halt_req", 32'(imem_req), 32'd0);
    check("t5_halt_incr", 32'(pc_incr), 32'd0);
    sample(2);
    check("t5_inflight_pushed", 32'(ir_valid), 32'd1);
    check("t5_inflight_pc", 32'(ir_pc), 32'd0);
    at_cyc(3);
    ir_ready = 1'b1;
    sample(4);
    check("t5_drained_valid", 32'(ir_valid), 32'd0);
    check("t5_still_halted", 32'(imem_req), 32'd0);
    check("t5_pc_held", 32'(imem_addr), 32'd1);
    at_cyc(6);
    halt = 1'b0;
    sample(6);
    check("t5_resume_req", 32'(imem_req), 32'd1);
    check("t5_resume_addr", 32'(imem_addr), 32'd1);
    at_cyc(8);
    halt = 1'b1;
    drained(12);

`ifdef FETCH_STATS_EN
    // statistics counters, including saturation of fetch_cnt
    do_reset();
    ir_ready = 1'b1;
    for (int i = 0; i < 65545; i++) expect_pc(AW'(i));
    sample(10);
    check("t6_fetch_cnt", 32'(fetch_cnt), 32'd8);
    check("t6_stall_cnt", 32'(stall_cnt), 32'd2);
    at_cyc(65545);
    halt = 1'b1;
    sample(65549);
    check("t6_fetch_sat", 32'(fetch_cnt), 32'hFFFF);
    drained(65550);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
